// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sevseg_pkg
//  Purpose  : Shared types and constants for the seven-segment port latch
//             and its sequential binary-to-BCD converter.
//  Revision : 1.0  initial release
// ============================================================================
package sevseg_pkg;

    // Converter sequencing states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Largest value representable in four BCD digits, and its BCD image
    localparam logic [15:0] BCD_MAX = 16'd9999;
    localparam logic [15:0] SAT_BCD = 16'h9999;

    // Default MCU output-port addresses
    localparam logic [7:0] DEF_PORT_LO   = 8'h81;
    localparam logic [7:0] DEF_PORT_HI   = 8'h82;
    localparam logic [7:0] DEF_PORT_CTRL = 8'h83;

endpackage
`default_nettype wire

// File: rtl/bcd_seq_conv.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seq_conv
//  Purpose  : Sequential double-dabble converter, one input bit per cycle.
//             START loads a new operand (also restarting a conversion in
//             flight); DONE is high during the sixteenth shift cycle, and
//             BCD holds the final result from the following cycle onwards.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_seq_conv
    import sevseg_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] BIN,
    output logic [15:0] BCD,
    output logic        DONE
);

    state_t      r_state;
    logic [15:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_count;
    logic [15:0] w_adj;

    // Add-3 correction on every digit that would overflow when doubled
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
            assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                      (r_bcd[gi*4 +: 4] + 4'd3) :
                                      r_bcd[gi*4 +: 4];
        end
    endgenerate

    assign DONE = (r_state == SHIFT) && (r_count == 4'd15);
    assign BCD  = r_bcd;

    // Load on START, otherwise shift {bcd, bin} once per SHIFT cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_bin   <= 16'h0000;
            r_bcd   <= 16'h0000;
            r_count <= 4'd0;
        end else if (START) begin
            r_state <= SHIFT;
            r_bin   <= BIN;
            r_bcd   <= 16'h0000;
            r_count <= 4'd0;
        end else begin
            case (r_state)
                SHIFT: begin
                    r_bcd   <= {w_adj[14:0], r_bin[15]};
                    r_bin   <= {r_bin[14:0], 1'b0};
                    r_count <= r_count + 4'd1;
                    if (r_count == 4'd15) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sevseg_port_latch.sv
`default_nettype none
// ============================================================================
//  Module   : sevseg_port_latch
//  Purpose  : Captures MCU low/high/control port writes into an atomic
//             16-bit value and presents it to the display driver either as
//             raw hex or as packed BCD saturated at 9999.
//  Revision : 1.0  initial release
// ============================================================================
module sevseg_port_latch
    import sevseg_pkg::*;
#(
    parameter logic [7:0] PORT_LO   = DEF_PORT_LO,
    parameter logic [7:0] PORT_HI   = DEF_PORT_HI,
    parameter logic [7:0] PORT_CTRL = DEF_PORT_CTRL
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  PORT_ID,
    input  logic [7:0]  OUT_PORT,
    input  logic        IO_STRB,
    output logic [15:0] DISP_DATA,
    output logic        DEC_MODE,
    output logic        BUSY
);

    logic [7:0]  r_lo_stage;
    logic [15:0] r_value;
    logic        r_dec_mode;
    logic [15:0] r_disp;
    logic        r_busy;
    logic        r_done_q;

    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_wr_ctrl;
    logic        w_commit;
    logic [15:0] w_value_next;
    logic        w_mode_next;
    logic [15:0] w_bin_clamped;
    logic        w_conv_start;
    logic        w_conv_done;
    logic [15:0] w_conv_bcd;
    logic        w_unused_ctrl;

    assign w_wr_lo   = IO_STRB && (PORT_ID == PORT_LO);
    assign w_wr_hi   = IO_STRB && (PORT_ID == PORT_HI);
    assign w_wr_ctrl = IO_STRB && (PORT_ID == PORT_CTRL);
    assign w_commit  = w_wr_hi || w_wr_ctrl;

    // Value and mode as they will be after this cycle's write
    assign w_value_next  = w_wr_hi   ? {OUT_PORT, r_lo_stage} : r_value;
    assign w_mode_next   = w_wr_ctrl ? OUT_PORT[0]            : r_dec_mode;
    assign w_bin_clamped = (w_value_next > BCD_MAX) ? BCD_MAX : w_value_next;
    assign w_conv_start  = w_commit && w_mode_next;

    // Upper control bits carry no meaning
    assign w_unused_ctrl = ^OUT_PORT[7:1];

    bcd_seq_conv u_conv (
        .CLK   (CLK),
        .RST   (RST),
        .START (w_conv_start),
        .BIN   (w_bin_clamped),
        .BCD   (w_conv_bcd),
        .DONE  (w_conv_done)
    );

    // Port registers, busy tracking and display update; a commit always
    // overrides a finishing conversion so the last commit wins
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lo_stage <= 8'h00;
            r_value    <= 16'h0000;
            r_dec_mode <= 1'b0;
            r_disp     <= 16'h0000;
            r_busy     <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_done_q <= 1'b0;
            if (w_wr_lo) begin
                r_lo_stage <= OUT_PORT;
            end
            if (w_wr_hi) begin
                r_value <= w_value_next;
            end
            if (w_wr_ctrl) begin
                r_dec_mode <= w_mode_next;
            end
            if (w_commit) begin
                if (w_mode_next) begin
                    r_busy <= 1'b1;
                end else begin
                    r_busy <= 1'b0;
                    r_disp <= w_value_next;
                end
            end else begin
                // A converter finishing after a hex commit is ignored via r_busy
                if (r_busy && w_conv_done) begin
                    r_busy   <= 1'b0;
                    r_done_q <= 1'b1;
                end
                if (r_done_q) begin
                    r_disp <= w_conv_bcd;
                end
            end
        end
    end

    assign DISP_DATA = r_disp;
    assign DEC_MODE  = r_dec_mode;
    assign BUSY      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sevseg_port_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sevseg_port_latch
//  Purpose  : Self-checking bench for sevseg_port_latch.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sevseg_port_latch;

    localparam logic [7:0] P_LO   = 8'h81;
    localparam logic [7:0] P_HI   = 8'h82;
    localparam logic [7:0] P_CTRL = 8'h83;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  PORT_ID = 8'h00;
    logic [7:0]  OUT_PORT = 8'h00;
    logic        IO_STRB = 1'b0;
    logic [15:0] DISP_DATA;
    logic        DEC_MODE;
    logic        BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  port;
        logic [7:0]  data;
        logic        strb;
        int          lat;      // 0 = display must hold, 1 = hex, 17 = decimal
        logic [15:0] exp_disp;
        logic        exp_mode;
    } vec_t;

    typedef struct {
        int          lat;
        logic [15:0] exp_disp;
        logic        exp_mode;
        logic [15:0] old_disp;
    } exp_t;

    vec_t        vecs[18];
    exp_t        sb_q[$];
    logic [15:0] cur_disp;

    sevseg_port_latch dut (
        .CLK       (CLK),
        .RST       (RST),
        .PORT_ID   (PORT_ID),
        .OUT_PORT  (OUT_PORT),
        .IO_STRB   (IO_STRB),
        .DISP_DATA (DISP_DATA),
        .DEC_MODE  (DEC_MODE),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the strobe edge
    task automatic wr(input logic [7:0] port, input logic [7:0] data, input logic strb);
        PORT_ID  = port;
        OUT_PORT = data;
        IO_STRB  = strb;
        @(posedge CLK);
        #1;
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Pops one expectation and follows the DUT through its latency
    task automatic drain(input string name);
        exp_t e;
        e = sb_q.pop_front();
        if (e.lat == 0) begin
            chk({name, "_hold"}, DISP_DATA, e.old_disp);
            chk({name, "_mode"}, {15'd0, DEC_MODE}, {15'd0, e.exp_mode});
        end else if (e.lat == 1) begin
            chk({name, "_hex"}, DISP_DATA, e.exp_disp);
            chk({name, "_busy"}, {15'd0, BUSY}, 16'd0);
            chk({name, "_mode"}, {15'd0, DEC_MODE}, {15'd0, e.exp_mode});
        end else begin
            chk({name, "_busy0"}, {15'd0, BUSY}, 16'd1);
            chk({name, "_mode"}, {15'd0, DEC_MODE}, {15'd0, e.exp_mode});
            for (int k = 1; k <= 16; k++) begin
                @(posedge CLK);
                #1;
                chk({name, "_hold"}, DISP_DATA, e.old_disp);
                if (k == 15) chk({name, "_busy15"}, {15'd0, BUSY}, 16'd1);
                if (k == 16) chk({name, "_busy16"}, {15'd0, BUSY}, 16'd0);
            end
            @(posedge CLK);
            #1;
            chk({name, "_dec"}, DISP_DATA, e.exp_disp);
        end
        cur_disp = e.exp_disp;
    endtask

    task automatic push(input int lat, input logic [15:0] d, input logic m);
        exp_t e;
        e.lat      = lat;
        e.exp_disp = (lat == 0) ? cur_disp : d;
        e.exp_mode = m;
        e.old_disp = cur_disp;
        sb_q.push_back(e);
    endtask

    initial begin
        vecs[0]  = '{P_LO,   8'h34, 1'b1, 0,  16'h0000, 1'b0};
        vecs[1]  = '{P_HI,   8'h12, 1'b1, 1,  16'h1234, 1'b0};
        vecs[2]  = '{P_LO,   8'hFF, 1'b1, 0,  16'h1234, 1'b0};
        vecs[3]  = '{P_LO,   8'hD2, 1'b1, 0,  16'h1234, 1'b0};
        vecs[4]  = '{P_HI,   8'h04, 1'b1, 1,  16'h04D2, 1'b0};
        vecs[5]  = '{P_CTRL, 8'h01, 1'b1, 17, 16'h1234, 1'b1};
        vecs[6]  = '{P_LO,   8'hFF, 1'b1, 0,  16'h1234, 1'b1};
        vecs[7]  = '{P_HI,   8'hFF, 1'b1, 17, 16'h9999, 1'b1};
        vecs[8]  = '{P_LO,   8'h0F, 1'b1, 0,  16'h9999, 1'b1};
        vecs[9]  = '{P_HI,   8'h27, 1'b1, 17, 16'h9999, 1'b1};
        vecs[10] = '{P_LO,   8'h00, 1'b1, 0,  16'h9999, 1'b1};
        vecs[11] = '{P_HI,   8'h00, 1'b1, 17, 16'h0000, 1'b1};
        vecs[12] = '{P_LO,   8'h39, 1'b1, 0,  16'h0000, 1'b1};
        vecs[13] = '{P_HI,   8'h30, 1'b1, 17, 16'h9999, 1'b1};
        vecs[14] = '{8'h80,  8'h55, 1'b1, 0,  16'h9999, 1'b1};
        vecs[15] = '{P_HI,   8'h55, 1'b0, 0,  16'h9999, 1'b1};
        vecs[16] = '{P_CTRL, 8'hFE, 1'b1, 1,  16'h3039, 1'b0};
        vecs[17] = '{P_CTRL, 8'h03, 1'b1, 17, 16'h9999, 1'b1};

        // Reset state
        #2;
        chk("rst_disp", DISP_DATA, 16'h0000);
        chk("rst_busy", {15'd0, BUSY}, 16'd0);
        chk("rst_mode", {15'd0, DEC_MODE}, 16'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cur_disp = 16'h0000;
        idle(1);

        // Table-driven port writes
        for (int i = 0; i < 18; i++) begin
            wr(vecs[i].port, vecs[i].data, vecs[i].strb);
            push(vecs[i].lat, vecs[i].exp_disp, vecs[i].exp_mode);
            drain($sformatf("vec%0d", i));
        end

        // Restart: commit 100, then commit 7 on cycle 8 of the conversion
        wr(P_LO, 8'h64, 1'b1);
        wr(P_HI, 8'h00, 1'b1);
        wr(P_LO, 8'h07, 1'b1);
        for (int k = 2; k < 8; k++) begin
            chk("restart_hold", DISP_DATA, 16'h9999);
            idle(1);
        end
        wr(P_HI, 8'h00, 1'b1);
        push(17, 16'h0007, 1'b1);
        drain("restart");
        idle(20);
        chk("restart_final", DISP_DATA, 16'h0007);

        // Hex commit during a decimal conversion aborts it
        wr(P_LO, 8'h10, 1'b1);
        wr(P_HI, 8'h00, 1'b1);
        idle(3);
        wr(P_CTRL, 8'h00, 1'b1);
        push(1, 16'h0010, 1'b0);
        drain("abort_hex");
        idle(20);
        chk("abort_hold", DISP_DATA, 16'h0010);
        chk("abort_busy", {15'd0, BUSY}, 16'd0);

        // Asynchronous reset mid-conversion
        wr(P_CTRL, 8'h01, 1'b1);
        idle(5);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_disp", DISP_DATA, 16'h0000);
        chk("arst_busy", {15'd0, BUSY}, 16'd0);
        chk("arst_mode", {15'd0, DEC_MODE}, 16'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cur_disp = 16'h0000;
        idle(20);
        chk("arst_after", DISP_DATA, 16'h0000);

        // Back-to-back strobes: last commit wins
        wr(P_LO, 8'h11, 1'b1);
        wr(P_HI, 8'h22, 1'b1);
        chk("b2b_first", DISP_DATA, 16'h2211);
        wr(P_HI, 8'h33, 1'b1);
        chk("b2b_last", DISP_DATA, 16'h3311);
        idle(2);
        chk("b2b_hold", DISP_DATA, 16'h3311);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
